serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller that sequences a single `full_adder` instance across `WIDTH` clock cycles to add two `WIDTH`-bit operands. It provides a start/busy/done handshake, registered result outputs and a carry chain held in a flip-flop. It sits between the board-level operand source (switches or PS-driven registers) and the result display or readback logic. It is the area-minimal alternative to the ripple and lookahead adders.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `i_clk` in 1: system clock. All logic is rising-edge.
- `i_rst_n` in 1: reset, **synchronous, active-low**. Single clock domain, no other clocks.
- `i_start` in 1: request to begin an addition. Sampled only in IDLE.
- `i_op_a` in WIDTH: operand A. Sampled on the accepting edge.
- `i_op_b` in WIDTH: operand B. Sampled on the accepting edge.
- `i_carry` in 1: carry-in. Sampled on the accepting edge.
- `o_busy` out 1: high in RUN and DONE.
- `o_done` out 1: one-cycle pulse when the result is valid.
- `o_sum` out WIDTH: registered sum. Held between operations.
- `o_carry` out 1: registered carry-out. Held between operations.

## Operation
- The block instantiates exactly one `full_adder`. Its inputs are:
  - `i_bit1` = LSB of shift register A;
  - `i_bit2` = LSB of shift register B;
  - `i_carry` = the carry flip-flop.
- State machine states are IDLE, RUN and DONE; encoding is free.
- IDLE:
  - `i_start`=1 → load A, B and the carry flop from the inputs, clear the bit counter, clear the result shift register, go to RUN.
  - `i_start`=0 → stay in IDLE.
- RUN, on every edge:
  - shift A and B right by 1;
  - shift the adder `o_sum` into the result register MSB (result shifts right, so bit 0 ends up at LSB after WIDTH shifts);
  - load the carry flop from the adder `o_carry`;
  - increment the counter.
- When the counter is WIDTH-1 on an edge in RUN, that edge also:
  - copies the completed result into `o_sum` and the final carry into `o_carry`;
  - moves the state to DONE.
- DONE: `o_done`=1 for this single cycle. The next edge goes to IDLE unconditionally.
- `i_start` asserted in RUN or DONE is ignored. It is not queued.
- Arithmetic: {`o_carry`,`o_sum`} = A + B + carry-in, modulo 2^(WIDTH+1). No overflow flag.
- `o_sum` and `o_carry` change only on the completing edge. Intermediate partial results are never visible on them.
- Operand inputs may change freely after the accepting edge without affecting the operation in flight.

## Timing
- Reset (edge with `i_rst_n`=0):
  - state goes to IDLE;
  - `o_busy`=0, `o_done`=0, `o_sum`=0, `o_carry`=0;
  - internal registers are cleared.
- Reset applied mid-operation aborts the operation. No `o_done` pulse is produced and the outputs go to 0.
- Accepting edge E0 (IDLE and `i_start`=1): `o_busy` is high from after E0.
- Bit k (k=0..WIDTH-1) is computed during the cycle before edge E(k+1).
- Result is valid, and `o_done`=1, after edge E(WIDTH). For WIDTH=8 that is 8 cycles after the accepting edge.
- After E(WIDTH+1): `o_done`=0, `o_busy`=0, state is IDLE.
- Earliest next accept is E(WIDTH+2), when `i_start` is held high.
- Throughput: one addition per WIDTH+2 cycles with `i_start` held continuously.
- `i_start`=1 in IDLE with `i_rst_n`=0 on the same edge: reset wins and the start is not accepted.

## Test plan
- **Basic add:** WIDTH=8, A=0x5A, B=0x3C, cin=0, single-cycle start.
  - `o_done` high exactly 8 cycles after the accepting edge.
  - `o_sum`=0x96, `o_carry`=0.
  - `o_busy` high for 9 cycles.
- **Wrap-around:** A=0xFF, B=0x01, cin=0.
  - `o_sum`=0x00, `o_carry`=1.
  - Result is held until the next completion.
- **Max with carry-in:** A=0xFF, B=0xFF, cin=1.
  - `o_sum`=0xFF, `o_carry`=1.
  - Then A=0, B=0, cin=0 gives `o_sum`=0x00, `o_carry`=0.
- **Start while busy:** pulse `i_start` with new operands 3 cycles into RUN and again in the DONE cycle.
  - Both pulses are ignored.
  - Result matches the original operands.
  - Only one `o_done` pulse occurs.
- **Reset mid-operation:** assert `i_rst_n`=0 for 1 cycle at bit 4.
  - All outputs are 0 the next cycle and the state is IDLE.
  - No `o_done` pulse.
  - A fresh start (A=0x10, B=0x20) returns 0x30.
- **Back-to-back and random:** hold `i_start`=1 and check accepts every 10 cycles. Then run 1000 random operand/cin sets against a reference model at WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder is stepped across WIDTH cycles behind a
// start/busy/done handshake, with the running carry kept in a flip-flop.

module full_adder (
    input  logic i_bit1,
    input  logic i_bit2,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_bit1 ^ i_bit2 ^ i_carry;
    assign o_carry = (i_bit1 & i_bit2) | (i_carry & (i_bit1 ^ i_bit2));

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_carry,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] result_sr;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             carry_out_q;
    logic [CW-1:0]    count;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    full_adder u_fa (
        .i_bit1  (shift_a[0]),
        .i_bit2  (shift_b[0]),
        .i_carry (carry_q),
        .o_sum   (fa_sum),
        .o_carry (fa_carry)
    );

    assign last_bit = (count == CW'(WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start request is only honoured from IDLE; RUN and DONE ignore it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts;
    // the visible outputs are only written on the completing edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            shift_a     <= '0;
            shift_b     <= '0;
            result_sr   <= '0;
            carry_q     <= 1'b0;
            count       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        shift_a   <= i_op_a;
                        shift_b   <= i_op_b;
                        carry_q   <= i_carry;
                        count     <= '0;
                        result_sr <= '0;
                    end
                end
                RUN: begin
                    shift_a   <= shift_a >> 1;
                    shift_b   <= shift_b >> 1;
                    result_sr <= {fa_sum, result_sr[WIDTH-1:1]};
                    carry_q   <= fa_carry;
                    count     <= count + CW'(1);
                    if (last_bit) begin
                        sum_q       <= {fa_sum, result_sr[WIDTH-1:1]};
                        carry_out_q <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == DONE);
    assign o_sum   = sum_q;
    assign o_carry = carry_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised checks of serial_adder_ctrl at WIDTH=8 and WIDTH=16.

module tb_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        cout;

    logic        start16;
    logic [15:0] op_a16;
    logic [15:0] op_b16;
    logic        cin16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    int checks_total;
    int checks_passed;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_op_a  (op_a),
        .i_op_b  (op_b),
        .i_carry (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_carry (cout)
    );

    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start16),
        .i_op_a  (op_a16),
        .i_op_b  (op_b16),
        .i_carry (cin16),
        .o_busy  (busy16),
        .o_done  (done16),
        .o_sum   (sum16),
        .o_carry (cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one 8-bit addition and watches a fixed window after the accept edge.
    task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           output int lat, output int busy_cnt, output int done_cnt);
        op_a = a;
        op_b = b;
        cin = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a = ~a;
        op_b = ~b;
        cin = ~c;
        lat = -1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    task automatic do_add16(input logic [15:0] a, input logic [15:0] b, input logic c,
                            output int done_cnt);
        op_a16 = a;
        op_b16 = b;
        cin16 = c;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        op_a16 = ~a;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            if (done16) done_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        start16 = 1'b1;
        tick();
        tick();
        checks_total++;
        if ({busy, done, sum, cout} !== 11'h000) $display("[TB] FAIL reset8 got busy=%b done=%b sum=%h c=%b want all 0", busy, done, sum, cout);
        else checks_passed++;
        checks_total++;
        if ({busy16, done16, sum16, cout16} !== 19'h00000) $display("[TB] FAIL reset16 got busy=%b done=%b sum=%h c=%b want all 0", busy16, done16, sum16, cout16);
        else checks_passed++;
        rst_n = 1'b1;
        start = 1'b0;
        start16 = 1'b0;
        tick();
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_start got busy=%b want 0", busy);
        else checks_passed++;
    endtask

    task automatic test_basic();
        int lat, bc, dc;
        do_add8(8'h5A, 8'h3C, 1'b0, lat, bc, dc);
        checks_total++;
        if (lat !== 8) $display("[TB] FAIL basic_latency got %0d want 8", lat);
        else checks_passed++;
        checks_total++;
        if ({cout, sum} !== 9'h096) $display("[TB] FAIL basic_sum got %b_%h want 0_96", cout, sum);
        else checks_passed++;
        checks_total++;
        if (bc !== 9) $display("[TB] FAIL basic_busy got %0d cycles want 9", bc);
        else checks_passed++;
        checks_total++;
        if (dc !== 1) $display("[TB] FAIL basic_done_pulses got %0d want 1", dc);
        else checks_passed++;
    endtask

    task automatic test_wrap();
        int lat, bc, dc;
        do_add8(8'hFF, 8'h01, 1'b0, lat, bc, dc);
        checks_total++;
        if ({cout, sum} !== 9'h100) $display("[TB] FAIL wrap_sum got %b_%h want 1_00", cout, sum);
        else checks_passed++;
        op_a = 8'h77;
        op_b = 8'h66;
        cin = 1'b1;
        repeat (6) tick();
        checks_total++;
        if ({cout, sum} !== 9'h100) $display("[TB] FAIL wrap_hold got %b_%h want 1_00", cout, sum);
        else checks_passed++;
    endtask

    task automatic test_max_carry();
        int lat, bc, dc;
        do_add8(8'hFF, 8'hFF, 1'b1, lat, bc, dc);
        checks_total++;
        if ({cout, sum} !== 9'h1FF) $display("[TB] FAIL max_sum got %b_%h want 1_ff", cout, sum);
        else checks_passed++;
        do_add8(8'h00, 8'h00, 1'b0, lat, bc, dc);
        checks_total++;
        if ({cout, sum} !== 9'h000) $display("[TB] FAIL zero_sum got %b_%h want 0_00", cout, sum);
        else checks_passed++;
    endtask

    task automatic test_start_while_busy();
        int dc;
        int dc_cycle;
        dc = 0;
        dc_cycle = -1;
        op_a = 8'h21;
        op_b = 8'h43;
        cin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 3) begin
                op_a = 8'hF0;
                op_b = 8'h0F;
                cin = 1'b0;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) begin
                dc++;
                dc_cycle = i;
                start = 1'b1;
                op_a = 8'h01;
                op_b = 8'h01;
            end
        end
        checks_total++;
        if ({cout, sum} !== 9'h065) $display("[TB] FAIL busy_start_sum got %b_%h want 0_65", cout, sum);
        else checks_passed++;
        checks_total++;
        if (dc !== 1 || dc_cycle !== 8) $display("[TB] FAIL busy_start_done got %0d pulses at %0d want 1 at 8", dc, dc_cycle);
        else checks_passed++;
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL busy_start_idle got busy=%b want 0", busy);
        else checks_passed++;
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, dc;
        op_a = 8'hAA;
        op_b = 8'h54;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks_total++;
        if ({busy, done, sum, cout} !== 11'h000) $display("[TB] FAIL midreset_out got busy=%b done=%b sum=%h c=%b want all 0", busy, done, sum, cout);
        else checks_passed++;
        dc = 0;
        repeat (12) begin
            tick();
            if (done) dc++;
        end
        checks_total++;
        if (dc !== 0) $display("[TB] FAIL midreset_nodone got %0d pulses want 0", dc);
        else checks_passed++;
        do_add8(8'h10, 8'h20, 1'b0, lat, bc, dc);
        checks_total++;
        if ({cout, sum} !== 9'h030) $display("[TB] FAIL midreset_fresh got %b_%h want 0_30", cout, sum);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        int rises[$];
        int dones;
        logic prev_busy;
        prev_busy = busy;
        dones = 0;
        op_a = 8'h12;
        op_b = 8'h34;
        cin = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (busy && !prev_busy) rises.push_back(i);
            prev_busy = busy;
            if (done) begin
                dones++;
                checks_total++;
                if ({cout, sum} !== 9'h047) $display("[TB] FAIL b2b_sum got %b_%h want 0_47", cout, sum);
                else checks_passed++;
            end
        end
        start = 1'b0;
        repeat (12) tick();
        checks_total++;
        if (rises.size() !== 4) $display("[TB] FAIL b2b_accepts got %0d want 4", rises.size());
        else checks_passed++;
        for (int k = 1; k < rises.size(); k++) begin
            checks_total++;
            if (rises[k] - rises[k-1] !== 10) $display("[TB] FAIL b2b_interval got %0d want 10", rises[k] - rises[k-1]);
            else checks_passed++;
        end
        checks_total++;
        if (dones < 3) $display("[TB] FAIL b2b_dones got %0d want >=3", dones);
        else checks_passed++;
    endtask

    task automatic test_random();
        int lat, bc, dc;
        logic [7:0]  a, b;
        logic        c;
        logic [8:0]  exp8;
        logic [15:0] a16, b16;
        logic [16:0] exp16;
        int errs8, errs16;
        errs8 = 0;
        errs16 = 0;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            exp8 = {1'b0, a} + {1'b0, b} + {8'b0, c};
            do_add8(a, b, c, lat, bc, dc);
            checks_total++;
            if ({cout, sum} !== exp8 || lat !== 8) begin
                errs8++;
                if (errs8 <= 5) $display("[TB] FAIL rand8 %h+%h+%b got %b_%h lat %0d want %h lat 8", a, b, c, cout, sum, lat, exp8);
            end else checks_passed++;
        end
        for (int n = 0; n < 1000; n++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c = 1'($urandom);
            exp16 = {1'b0, a16} + {1'b0, b16} + {16'b0, c};
            do_add16(a16, b16, c, dc);
            checks_total++;
            if ({cout16, sum16} !== exp16 || dc !== 1) begin
                errs16++;
                if (errs16 <= 5) $display("[TB] FAIL rand16 %h+%h+%b got %b_%h done %0d want %h done 1", a16, b16, c, cout16, sum16, dc, exp16);
            end else checks_passed++;
        end
    endtask

    initial begin
        checks_total = 0;
        checks_passed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op_a = '0;
        op_b = '0;
        cin = 1'b0;
        start16 = 1'b0;
        op_a16 = '0;
        op_b16 = '0;
        cin16 = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_max_carry();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
